fifo_rd_streamer: RTL and testbench

Read-side consumer for the team's synchronous FIFO. It drives `rd_en`, captures the FIFO's registered `data_out`, and presents words on a valid/ready output stream through a 2-entry skid buffer. It never reads an empty FIFO, tolerates downstream stalls without losing data, and supports a flush mode that drains and discards FIFO contents. It sits between the FIFO instance and the downstream packet consumer.

---
 rtl/fifo_rd_streamer_pkg.sv | 13 +
 rtl/fifo_rd_streamer_skid_buf.sv | 63 ++++++
 rtl/fifo_rd_streamer_sva.sv | 26 ++
 rtl/fifo_rd_streamer.sv | 109 ++++++++++
 tb/tb_fifo_rd_streamer.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_streamer_pkg.sv
// rtl/fifo_rd_streamer_pkg.sv - shared FIFO constants and read-streamer state type
package fifo_rd_streamer_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } rd_state_e;

endpackage

// File: rtl/fifo_rd_streamer_skid_buf.sv
// rtl/fifo_rd_streamer_skid_buf.sv - 2-entry valid/ready buffer with synchronous clear
module stream_skid_buf #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       cnt;
    logic             pop;

    assign m_valid = (cnt != 2'd0);
    assign m_data  = head;
    assign count   = cnt;
    assign pop     = m_valid && m_ready;

    // Head only changes on pop or when empty, so m_data holds under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= 2'd0;
        end else if (clear) begin
            cnt <= 2'd0;
        end else begin
            case ({s_valid, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        head <= s_data;
                    end else if (cnt == 2'd1) begin
                        tail <= s_data;
                    end
                    if (cnt != 2'd2) begin
                        cnt <= cnt + 2'd1;
                    end
                end
                2'b01: begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        head <= s_data;
                    end else begin
                        head <= tail;
                        tail <= s_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_streamer_sva.sv
// rtl/fifo_rd_streamer_sva.sv - protocol properties bound into fifo_rd_streamer
module fifo_rd_streamer_sva #(
    parameter int FIFO_WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic                  fifo_empty,
    input logic                  fifo_rd_en,
    input logic                  m_valid,
    input logic                  m_ready,
    input logic [FIFO_WIDTH-1:0] m_data,
    input logic                  flush_done
);

    a_no_read_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_rd_en && fifo_empty));

    a_data_stable_stall: assert property (@(posedge clk) disable iff (!rst_n)
        (m_valid && !m_ready) |=> $stable(m_data));

    a_flush_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        flush_done |=> !flush_done);

endmodule

bind fifo_rd_streamer fifo_rd_streamer_sva #(.FIFO_WIDTH(FIFO_WIDTH)) u_sva (.*);

// File: rtl/fifo_rd_streamer.sv
// rtl/fifo_rd_streamer.sv - FIFO read-side consumer feeding a valid/ready stream with flush
module fifo_rd_streamer #(
    parameter int FIFO_WIDTH = fifo_rd_streamer_pkg::FIFO_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  flush_done,
    output logic                  underflow_err,
    output logic [CNT_WIDTH-1:0]  words_out
);

    import fifo_rd_streamer_pkg::*;

    localparam int SKID_DEPTH = 2;

    rd_state_e            state;
    rd_state_e            state_next;
    logic                 inflight;
    logic [1:0]           skid_cnt;
    logic                 pop;
    logic                 capture;
    logic                 skid_clear;
    logic                 rd_ok;
    logic [2:0]           occ_eff;
    logic [CNT_WIDTH-1:0] words_cnt;

    assign pop        = m_valid && m_ready;
    // Counting this cycle's pop lets a read issue every cycle while draining.
    assign occ_eff    = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign rd_ok      = !fifo_empty && (occ_eff < 3'(SKID_DEPTH));
    assign skid_clear = flush || (state == FLUSH);
    assign capture    = inflight && !skid_clear;
    assign busy       = (state != IDLE) || (skid_cnt != 2'd0);
    assign words_out  = words_cnt;

    always_comb begin
        state_next = state;
        fifo_rd_en = 1'b0;
        flush_done = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                fifo_rd_en = rd_ok;
                if (!en) begin
                    state_next = IDLE;
                end
            end
            FLUSH: begin
                fifo_rd_en = rd_ok;
                if (fifo_empty && !inflight) begin
                    state_next = IDLE;
                    flush_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush && (state != FLUSH)) begin
            state_next = FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            inflight      <= 1'b0;
            words_cnt     <= '0;
            underflow_err <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= fifo_rd_en;
            if (pop && (state != FLUSH)) begin
                words_cnt <= words_cnt + 1'b1;
            end
            if (fifo_underflow) begin
                underflow_err <= 1'b1;
            end
        end
    end

    stream_skid_buf #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (skid_clear),
        .s_valid (capture),
        .s_data  (fifo_data_out),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .count   (skid_cnt)
    );

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb/tb_fifo_rd_streamer.sv - self-checking bench with queue FIFO model and scoreboard
module tb_fifo_rd_streamer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         flush = 1'b0;
    logic         fifo_empty = 1'b1;
    logic         fifo_underflow;
    logic [W-1:0] fifo_data_out = '0;
    logic         fifo_rd_en;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_ready = 1'b0;
    logic         busy;
    logic         flush_done;
    logic         underflow_err;
    logic [15:0]  words_out;

    logic         wr_en = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         uf_model = 1'b0;
    logic         uf_force = 1'b0;
    logic [W-1:0] mem[$];
    logic [W-1:0] exp_q[$];

    int tests = 0;
    int fails = 0;
    int hs_cnt = 0;
    int rd_cnt = 0;
    int exp_words = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    assign fifo_underflow = uf_model | uf_force;

    fifo_rd_streamer #(.FIFO_WIDTH(W), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .flush          (flush),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .busy           (busy),
        .flush_done     (flush_done),
        .underflow_err  (underflow_err),
        .words_out      (words_out)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous FIFO: registered data_out, empty follows the stored count.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem.delete();
            uf_model   <= 1'b0;
            fifo_empty <= 1'b1;
        end else begin
            uf_model <= fifo_rd_en && (mem.size() == 0);
            if (fifo_rd_en && mem.size() != 0) fifo_data_out <= mem.pop_front();
            if (wr_en) mem.push_back(wr_data);
            fifo_empty <= (mem.size() == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted word must be the oldest word written and not discarded.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_stall = 1'b0;
            exp_words  = 0;
        end else begin
            check("no_rd_when_empty", {31'd0, fifo_rd_en && fifo_empty}, 32'd0);
            check("words_out_track", {16'd0, words_out}, {16'd0, exp_words[15:0]});
            if (prev_stall) check("stall_hold", {16'd0, m_data}, {16'd0, prev_data});
            if (fifo_rd_en) rd_cnt++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_word: got 0x%0h, expected no word", m_data);
                end else begin
                    check("stream_data", {16'd0, m_data}, {16'd0, exp_q.pop_front()});
                end
                exp_words++;
                hs_cnt++;
            end
            prev_stall = m_valid && !m_ready && !flush;
            prev_data  = m_data;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_words(input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = base + W'(i);
            exp_q.push_back(wr_data);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        cyc(1);
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_valid"}, {31'd0, m_valid}, 0);
        check({tag, "_m_data"}, {16'd0, m_data}, 0);
        check({tag, "_rd_en"}, {31'd0, fifo_rd_en}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_flush_done"}, {31'd0, flush_done}, 0);
        check({tag, "_underflow_err"}, {31'd0, underflow_err}, 0);
        check({tag, "_words_out"}, {16'd0, words_out}, 0);
    endtask

    typedef struct {
        int          n;
        int          stall;
        logic [15:0] base;
        int          stall_reads;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int k, hs, first_rd, first_v, first_hs, last_hs, sreads, pulses, rd0, h0;
        logic [W-1:0] first_data;
        logic [15:0]  w0;

        vecs[0] = '{8, 0, 16'h0001, -1};
        vecs[1] = '{4, 6, 16'h0001, 2};
        vecs[2] = '{1, 4, 16'hfff0, 1};
        vecs[3] = '{5, 3, 16'h8000, 2};
        vecs[4] = '{2, 0, 16'habcd, -1};

        cyc(2);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);

        for (int v = 0; v < 5; v++) begin
            push_words(vecs[v].n, vecs[v].base);
            w0 = words_out;
            hs = 0; k = 0; sreads = 0;
            first_rd = -1; first_v = -1; first_hs = -1; last_hs = -1; first_data = '0;
            while (hs < vecs[v].n && k < 80) begin
                en      = 1'b1;
                m_ready = (k >= vecs[v].stall);
                #1;
                if (fifo_rd_en && first_rd < 0) first_rd = k;
                if (fifo_rd_en && k < vecs[v].stall) sreads++;
                if (m_valid && first_v < 0) first_v = k;
                if (m_valid && m_ready) begin
                    if (first_hs < 0) begin
                        first_hs   = k;
                        first_data = m_data;
                    end
                    last_hs = k;
                    hs++;
                end
                @(negedge clk);
                k++;
            end
            en = 1'b0;
            check("tbl_latency", first_v - first_rd, 2);
            check("tbl_first_data", {16'd0, first_data}, {16'd0, vecs[v].base});
            check("tbl_delivered", hs, vecs[v].n);
            if (vecs[v].stall == 0) check("tbl_back_to_back", last_hs - first_hs, vecs[v].n - 1);
            if (vecs[v].stall_reads >= 0) check("tbl_stall_reads", sreads, vecs[v].stall_reads);
            cyc(2);
            check("tbl_words_out", {16'd0, 16'(words_out - w0)}, vecs[v].n);
            check("tbl_fifo_empty", {31'd0, fifo_empty}, 1);
        end

        // Flush with 2 words held in the skid buffer and 6 left in the FIFO.
        push_words(8, 16'h0100);
        en = 1'b1;
        m_ready = 1'b0;
        cyc(6);
        #1;
        check("flush_pre_valid", {31'd0, m_valid}, 1);
        w0 = words_out;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        en = 1'b0;
        #1;
        check("flush_valid_low", {31'd0, m_valid}, 0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (flush_done) pulses++;
            @(negedge clk);
            #1;
        end
        check("flush_pulses", pulses, 1);
        check("flush_fifo_empty", {31'd0, fifo_empty}, 1);
        check("flush_idle", {31'd0, busy}, 0);
        check("flush_words_out", {16'd0, words_out}, {16'd0, w0});
        exp_q.delete();
        @(negedge clk);

        // en dropped while the single read issued by RUN is still in flight.
        push_words(3, 16'h0200);
        m_ready = 1'b1;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        rd0 = 0; hs = 0; first_data = '0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (fifo_rd_en) rd0++;
            if (m_valid && m_ready) begin
                hs++;
                first_data = m_data;
            end
            @(negedge clk);
        end
        check("endrop_reads", rd0, 1);
        check("endrop_delivered", hs, 1);
        check("endrop_data", {16'd0, first_data}, 32'h0200);
        en = 1'b1;
        wait_drain(30, "endrop_rest_drained");
        en = 1'b0;

        // Single-word FIFO occupancy with a sparse concurrent writer.
        rd0 = rd_cnt;
        h0  = hs_cnt;
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = 16'h4000 + 16'(i);
            exp_q.push_back(wr_data);
            @(negedge clk);
            wr_en = 1'b0;
            cyc($urandom_range(0, 3));
        end
        wait_drain(40, "empty_drained");
        check("empty_reads", rd_cnt - rd0, 20);
        check("empty_words", hs_cnt - h0, 20);
        check("empty_no_underflow", {31'd0, underflow_err}, 0);

        // Randomised traffic against the scoreboard.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            en      = ($urandom_range(0, 9) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            wr_en   = $urandom_range(0, 1) == 1;
            wr_data = 16'($urandom);
            if (wr_en) exp_q.push_back(wr_data);
        end
        @(negedge clk);
        wr_en = 1'b0;
        en = 1'b1;
        m_ready = 1'b1;
        wait_drain(1000, "rand_drained");
        en = 1'b0;
        cyc(3);

        // Underflow flag is sticky.
        uf_force = 1'b1;
        @(negedge clk);
        uf_force = 1'b0;
        #1;
        check("underflow_set", {31'd0, underflow_err}, 1);
        cyc(3);
        #1;
        check("underflow_sticky", {31'd0, underflow_err}, 1);

        // Asynchronous reset in the middle of a clock phase while streaming.
        push_words(5, 16'h0300);
        en = 1'b1;
        m_ready = 1'b1;
        cyc(3);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        en = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        #1;
        check("post_reset_words", {16'd0, words_out}, 0);
        check("post_reset_valid", {31'd0, m_valid}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        tests++;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
